pool2x2_stream: RTL and testbench

Clocked, streaming 2x2 stride-2 pooling engine for the CNN datapath. It is the parametrised successor of the one-shot 2x2 averager. It accepts an N x N signed feature map one pixel per handshake in raster order, and emits the (N/2) x (N/2) pooled map in raster order. Each frame runs in average or max mode, selected per frame. A single-row line buffer of partial results allows arbitrary input stalls.

---
 rtl/pool2x2_stream.sv | 126 ++++++++++++
 tb/tb_pool2x2_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 pooling engine (average or max per frame) over an
// N x N signed raster; one row of partial window results is buffered.
module pool2x2_stream #(
  parameter int N  = 28,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_pixel,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_pixel,
  output logic                 busy,
  output logic                 finish,
  output logic [1:0]           state_dbg
);

  // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state. Outputs have no backpressure.

  localparam int CW = $clog2(N);
  localparam int HW = (N > 2) ? $clog2(N / 2) : 1;
  localparam int LD = 1 << HW;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((N % 2) != 0 || N < 2) begin : g_bad_param
      $error("pool2x2_stream: N must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                state;
  logic [CW-1:0]         r;
  logic [CW-1:0]         c;
  logic signed [DW-1:0]  hold;
  logic                  mode_q;
  logic signed [DW:0]    lb [LD];

  logic                  accept;
  logic [CW-1:0]         c_half;
  logic [HW-1:0]         lb_idx;
  logic signed [DW:0]    pair_sum;
  logic signed [DW-1:0]  pair_max;
  logic signed [DW:0]    lb_rd;
  logic signed [DW-1:0]  lb_max;
  logic signed [DW+1:0]  quad_sum;
  logic signed [DW+1:0]  quad_shr;
  logic signed [DW-1:0]  quad_max;

  assign accept    = in_valid && (state == RUN);
  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN);
  assign state_dbg = state;

  assign c_half   = c >> 1;
  assign lb_idx   = c_half[HW-1:0];
  assign pair_sum = {hold[DW-1], hold} + {in_pixel[DW-1], in_pixel};
  assign pair_max = (in_pixel > hold) ? in_pixel : hold;
  assign lb_rd    = lb[lb_idx];
  assign lb_max   = lb_rd[DW-1:0];
  // Four DW-bit values sum into DW+2 bits; >>> 2 floors toward -inf and always fits DW.
  assign quad_sum = {pair_sum[DW], pair_sum} + {lb_rd[DW], lb_rd};
  assign quad_shr = quad_sum >>> 2;
  assign quad_max = (lb_max > pair_max) ? lb_max : pair_max;

  // Top-row pair results; contents are don't-care out of reset.
  always_ff @(posedge clk) begin
    if (accept && c[0] && !r[0]) begin
      lb[lb_idx] <= mode_q ? {pair_max[DW-1], pair_max} : pair_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      hold      <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      finish    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      finish    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            r      <= '0;
            c      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (c == LAST) begin
              c <= '0;
              r <= r + 1'b1;
            end else begin
              c <= c + 1'b1;
            end
            if (!c[0]) begin
              hold <= in_pixel;
            end else if (r[0]) begin
              out_valid <= 1'b1;
              out_pixel <= mode_q ? quad_max : quad_shr[DW-1:0];
            end
            if (c == LAST && r == LAST) begin
              state  <= DONE;
              finish <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: an N=4 and an N=2 instance, scoreboarded against
// a frame-level pooling model.
module tb_pool2x2_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic        rst4_n, start4, mode4, iv4, ir4, ov4, busy4, fin4;
  logic [15:0] ip4, op4;
  logic [1:0]  st4;
  // N=2 instance
  logic        rst2_n, start2, mode2, iv2, ir2, ov2, busy2, fin2;
  logic [15:0] ip2, op2;
  logic [1:0]  st2;

  pool2x2_stream #(.N(4), .DW(16)) dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .mode(mode4),
    .in_valid(iv4), .in_pixel(ip4), .in_ready(ir4), .out_valid(ov4),
    .out_pixel(op4), .busy(busy4), .finish(fin4), .state_dbg(st4)
  );

  pool2x2_stream #(.N(2), .DW(16)) dut2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .mode(mode2),
    .in_valid(iv2), .in_pixel(ip2), .in_ready(ir2), .out_valid(ov2),
    .out_pixel(op2), .busy(busy2), .finish(fin2), .state_dbg(st2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] exp4_q[$];
  logic [16:0] exp2_q[$];
  int f4[$];
  int f2[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: each output = floor(mean) or max of a 2x2 window; the last
  // window of a frame also carries the finish flag.
  task automatic model_push(input int n, input bit m, input int f[$]);
    for (int wr = 0; wr < n / 2; wr++) begin
      for (int wc = 0; wc < n / 2; wc++) begin
        int a, b, cc, d, s, v;
        logic last;
        a  = f[(2 * wr) * n + 2 * wc];
        b  = f[(2 * wr) * n + 2 * wc + 1];
        cc = f[(2 * wr + 1) * n + 2 * wc];
        d  = f[(2 * wr + 1) * n + 2 * wc + 1];
        if (m) begin
          v = a;
          if (b > v) v = b;
          if (cc > v) v = cc;
          if (d > v) v = d;
        end else begin
          s = a + b + cc + d;
          v = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end
        last = (wr == n / 2 - 1) && (wc == n / 2 - 1);
        if (n == 4) exp4_q.push_back({last, 16'(v)});
        else        exp2_q.push_back({last, 16'(v)});
      end
    end
  endtask

  // Monitors: every out_valid pops one expected {finish, pixel}.
  always @(negedge clk) begin
    if (ov4) begin
      if (exp4_q.size() == 0) check("unexpected_out4", {15'd0, fin4, op4}, 32'h1ffff);
      else check("out4", {15'd0, fin4, op4}, {15'd0, exp4_q.pop_front()});
    end else if (fin4) begin
      check("finish4_alone", {31'd0, fin4}, 32'd0);
    end
    if (ov2) begin
      if (exp2_q.size() == 0) check("unexpected_out2", {15'd0, fin2, op2}, 32'h1ffff);
      else check("out2", {15'd0, fin2, op2}, {15'd0, exp2_q.pop_front()});
    end else if (fin2) begin
      check("finish2_alone", {31'd0, fin2}, 32'd0);
    end
  end

  function automatic int rand_pix();
    logic signed [15:0] s;
    s = 16'($urandom);
    return int'(s);
  endfunction

  // ---------------- N=4 driver ----------------
  task automatic start4_frame(input bit m);
    start4 = 1'b1; mode4 = m;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("busy4_run", {31'd0, busy4}, 32'd1);
  endtask

  task automatic put4(input int p, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    iv4 = 1'b1; ip4 = 16'(p);
    t = 0;
    while (!ir4 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready4", {31'd0, ir4}, 32'd1);
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic finish4_frame();
    check("busy4_done", {30'd0, busy4, ir4}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run4(input bit m, input int maxgap);
    start4_frame(m);
    model_push(4, m, f4);
    for (int i = 0; i < 16; i++) put4(f4[i], $urandom_range(0, maxgap));
    finish4_frame();
  endtask

  task automatic ramp4();
    f4.delete();
    for (int i = 1; i <= 16; i++) f4.push_back(i);
  endtask

  // ---------------- N=2 driver ----------------
  task automatic put2(input int p, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    iv2 = 1'b1; ip2 = 16'(p);
    t = 0;
    while (!ir2 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready2", {31'd0, ir2}, 32'd1);
    @(posedge clk); #1;
    iv2 = 1'b0;
  endtask

  task automatic run2(input bit m, input int maxgap);
    start2 = 1'b1; mode2 = m;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("busy2_run", {31'd0, busy2}, 32'd1);
    model_push(2, m, f2);
    for (int i = 0; i < 4; i++) put2(f2[i], $urandom_range(0, maxgap));
    check("busy2_done", {30'd0, busy2, ir2}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic fill2(input int a, input int b, input int c, input int d);
    f2.delete();
    f2.push_back(a); f2.push_back(b); f2.push_back(c); f2.push_back(d);
  endtask

  // ---------------- main sequences ----------------
  initial begin
    rst4_n = 1'b0; start4 = 1'b0; mode4 = 1'b0; iv4 = 1'b0; ip4 = '0;
    rst2_n = 1'b0; start2 = 1'b0; mode2 = 1'b0; iv2 = 1'b0; ip2 = '0;
    #2;
    check("reset4_outs", {12'd0, ov4, fin4, busy4, ir4, op4}, 32'd0);
    check("reset2_outs", {12'd0, ov2, fin2, busy2, ir2, op2}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst4_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;

    fork
      begin : seq4
        ramp4();
        run4(1'b0, 0);                   // 3, 5, 11, 13
        run4(1'b1, 0);                   // 6, 8, 14, 16
        f4.delete();
        for (int i = 0; i < 16; i++) f4.push_back(-5);
        run4(1'b1, 0);
        ramp4();
        run4(1'b0, 5);                   // stalled, same averages

        // start/mode held high through RUN and DONE must be ignored
        ramp4();
        start4_frame(1'b0);
        model_push(4, 1'b0, f4);
        start4 = 1'b1; mode4 = 1'b1;
        for (int i = 0; i < 16; i++) put4(f4[i], i % 3);
        check("busy4_done_prot", {30'd0, busy4, ir4}, 32'd0);
        @(posedge clk); #1;
        start4 = 1'b0; mode4 = 1'b0;
        check("no_restart4", {31'd0, busy4}, 32'd0);

        // in_valid in IDLE is not accepted
        iv4 = 1'b1; ip4 = 16'd77;
        for (int i = 0; i < 3; i++) begin
          check("idle_ready4", {31'd0, ir4}, 32'd0);
          @(posedge clk); #1;
        end
        iv4 = 1'b0;

        // abort after 9 of 16 pixels
        ramp4();
        start4_frame(1'b0);
        model_push(4, 1'b0, f4);
        for (int i = 0; i < 9; i++) put4(f4[i], 0);
        rst4_n = 1'b0;
        #1;
        check("abort4_outs", {12'd0, ov4, fin4, busy4, ir4, op4}, 32'd0);
        exp4_q.delete();
        @(posedge clk); #1;
        rst4_n = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
        end
        run4(1'b0, 0);                   // fresh frame: 3, 5, 11, 13

        for (int k = 0; k < 4; k++) begin
          f4.delete();
          for (int i = 0; i < 16; i++) f4.push_back(rand_pix());
          run4(1'($urandom_range(0, 1)), 3);
        end
      end
      begin : seq2
        fill2(-1, -2, -3, -4);           run2(1'b0, 0);   // -3
        fill2(32767, 32767, 32767, 32767); run2(1'b0, 1); // 32767
        fill2(-32768, -32768, -32768, -32768); run2(1'b0, 2); // -32768
        fill2(-32768, 32767, -1, 0);     run2(1'b1, 0);
        for (int k = 0; k < 8; k++) begin
          fill2(rand_pix(), rand_pix(), rand_pix(), rand_pix());
          run2(1'($urandom_range(0, 1)), 2);
        end
      end
    join

    begin
      int t;
      t = 0;
      while ((exp4_q.size() != 0 || exp2_q.size() != 0) && t < 200) begin
        @(posedge clk); t++;
      end
      check("drain_pending", 32'(exp4_q.size() + exp2_q.size()), 32'd0);
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
